// File: rtl/swim_pkg.sv
// Shared SWIM transmit definitions: FSM encoding, bit-timing multipliers, frame sizes,
// and the frame bit-select helper.
package swim_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBit,
    StAckWait,
    StAckLow,
    StDone
  } state_e;

  // Timing multipliers in units of SWIM clocks.
  localparam int unsigned MulLong  = 20;
  localparam int unsigned MulShort = 2;
  localparam int unsigned MulBit   = 22;
  localparam int unsigned MulAck   = 8;

  localparam int unsigned CmdBits  = 3;
  localparam int unsigned DataBits = 8;

  localparam int unsigned CntW = 16;

  // Index of the parity bit: start bit is 0, payload bits are 1..N.
  function automatic logic [3:0] last_idx(input logic is_cmd);
    return is_cmd ? 4'(CmdBits + 1) : 4'(DataBits + 1);
  endfunction

  function automatic logic frame_bit(input logic [7:0] data, input logic is_cmd,
                                     input logic [3:0] idx);
    logic [3:0] n;
    logic [2:0] sel;
    logic       par;
    n   = is_cmd ? 4'(CmdBits) : 4'(DataBits);
    par = is_cmd ? ^data[2:0] : ^data;
    sel = 3'(n - idx);
    if (idx == 4'd0) begin
      return 1'b0;
    end else if (idx > n) begin
      return par;
    end else begin
      return data[sel];
    end
  endfunction

endpackage

// File: rtl/swim_sync.sv
// Two-flop synchroniser for the SWIM pin with falling/rising edge detection
// on the synchronised level.
module swim_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall,
  output logic rise
);

  logic meta_q, sync_q, prev_q;

  // Flops reset high so an idle (pulled-up) line shows no spurious edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall = prev_q & ~sync_q;
  assign rise = ~prev_q & sync_q;

endmodule

// File: rtl/swim_tx.sv
// SWIM frame transmitter: sends a 3-bit command or 8-bit data frame with parity,
// decodes the target ACK/NACK pulse and retries on NACK.
module swim_tx
  import swim_pkg::*;
#(
  parameter int unsigned CLK_PER_SWIM = 6,
  parameter int unsigned ACK_TIMEOUT  = 1056,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] in_data,
  input  logic       in_is_cmd,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       swim_in,
  output logic       swim_oe,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam logic [CntW-1:0] LongLen    = CntW'(MulLong * CLK_PER_SWIM);
  localparam logic [CntW-1:0] ShortLen   = CntW'(MulShort * CLK_PER_SWIM);
  localparam logic [CntW-1:0] BitLen     = CntW'(MulBit * CLK_PER_SWIM);
  localparam logic [CntW-1:0] AckLim     = CntW'(MulAck * CLK_PER_SWIM);
  localparam logic [CntW-1:0] LowMax     = CntW'(2 * MulBit * CLK_PER_SWIM);
  localparam logic [CntW-1:0] TimeoutLen = CntW'(ACK_TIMEOUT);
  localparam logic [3:0]      RetryMax   = 4'(MAX_RETRY);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            cmd_q, cmd_d;
  logic [3:0]      retry_q, retry_d;
  logic            gap_q, gap_d;
  logic            ack_q, ack_d;
  logic            oe_q, oe_d;
  logic            accept;
  logic            fall, rise;

  swim_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (swim_in),
    .fall (fall),
    .rise (rise)
  );

  assign in_ready = en && rst && (state_q == StIdle);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != StIdle);
  assign swim_oe  = oe_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cmd_d   = cmd_q;
    retry_d = retry_q;
    gap_d   = gap_q;
    ack_d   = ack_q;
    done    = 1'b0;
    err     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBit;
          data_d  = in_data;
          cmd_d   = in_is_cmd;
          retry_d = '0;
          cnt_d   = '0;
          idx_d   = '0;
          gap_d   = 1'b0;
        end
      end
      StBit: begin
        // A resend is preceded by a short released gap counted in the same state.
        if (gap_q) begin
          if (cnt_q == ShortLen - 1'b1) begin
            gap_d = 1'b0;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q == BitLen - 1'b1) begin
          cnt_d = '0;
          if (idx_q == last_idx(cmd_q)) begin
            state_d = StAckWait;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAckWait: begin
        if (fall) begin
          state_d = StAckLow;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLen - 1'b1) begin
          err     = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAckLow: begin
        // Low time includes the cycle the falling edge was seen, hence the strict compare.
        if (rise) begin
          state_d = StDone;
          ack_d   = (cnt_q < AckLim);
        end else if (cnt_q == LowMax - 1'b1) begin
          err     = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (ack_q) begin
          done    = 1'b1;
          state_d = StIdle;
        end else if (retry_q == RetryMax) begin
          err     = 1'b1;
          state_d = StIdle;
        end else begin
          retry_d = retry_q + 1'b1;
          state_d = StBit;
          gap_d   = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    oe_d = (state_d == StBit) && !gap_d &&
           (cnt_d < (frame_bit(data_d, cmd_d, idx_d) ? ShortLen : LongLen));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      cmd_q   <= 1'b0;
      retry_q <= '0;
      gap_q   <= 1'b0;
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      retry_q <= retry_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      oe_q    <= oe_d;
    end
  end

endmodule

// File: tb/tb_swim_tx.sv
// Directed bench for swim_tx: a scoreboard of expected frame bits is filled on each
// send/resend and drained by a monitor that decodes the swim_oe pulse widths.
module tb_swim_tx;

  localparam int unsigned C      = 6;
  localparam int          BitLen = 22 * C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_is_cmd = 1'b0;
  logic       in_valid = 1'b0;
  logic       tgt_low = 1'b0;
  logic       in_ready, swim_oe, done, err, busy;
  logic       swim_in;

  // Open-drain pin: low if either the DUT or the target pulls it.
  assign swim_in = ~(swim_oe | tgt_low);

  always #5 clk = ~clk;

  swim_tx #(
    .CLK_PER_SWIM (C),
    .ACK_TIMEOUT  (1056),
    .MAX_RETRY    (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_data   (in_data),
    .in_is_cmd (in_is_cmd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .swim_in   (swim_in),
    .swim_oe   (swim_oe),
    .done      (done),
    .err       (err),
    .busy      (busy)
  );

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  int   bits_seen = 0;
  int   done_cycles = 0;
  int   err_cycles = 0;
  int   hi = 0, lo = 0, prev_hi = 0;
  logic mon_got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame(input logic [7:0] d, input logic is_cmd);
    int   n;
    logic p;
    n = is_cmd ? 3 : 8;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = n - 1; i >= 0; i--) begin
      exp_q.push_back(d[i]);
      p ^= d[i];
    end
    exp_q.push_back(p);
  endfunction

  // Monitor: decode each high pulse of swim_oe into a bit and check bit period.
  always @(negedge clk) begin
    if (!rst) begin
      hi = 0;
      lo = 0;
      prev_hi = 0;
    end else if (swim_oe) begin
      if (hi == 0 && prev_hi != 0 && prev_hi + lo <= BitLen + 8)
        chk("bit_period", prev_hi + lo, BitLen);
      hi++;
      lo = 0;
    end else begin
      if (hi != 0) begin
        mon_got = (hi == 20 * C) ? 1'b0 : (hi == 2 * C) ? 1'b1 : 1'bx;
        if (exp_q.size() == 0) chk("unexpected_bit", bits_seen, 32'hFFFF_FFFF);
        else chk("frame_bit", {31'b0, mon_got}, {31'b0, exp_q.pop_front()});
        bits_seen++;
        prev_hi = hi;
        hi = 0;
        lo = 0;
      end
      lo++;
    end
    if (done) done_cycles++;
    if (err) err_cycles++;
  end

  task automatic send(input logic [7:0] d, input logic c);
    int i;
    i = 0;
    @(negedge clk);
    while (!in_ready && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    in_data = d;
    in_is_cmd = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = ~d;
    in_is_cmd = ~c;
    push_frame(d, c);
    chk("oe_first_cycle", swim_oe, 1);
    chk("busy_in_frame", busy, 1);
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 6000 && bits_seen < n; i++) @(posedge clk);
    chk("bits_seen", bits_seen, n);
  endtask

  task automatic respond(input int len);
    repeat (130) @(negedge clk);
    tgt_low = 1'b1;
    repeat (len) @(negedge clk);
    tgt_low = 1'b0;
  endtask

  task automatic wait_resp();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = done | err;
    end
    chk("response_seen", seen, 1);
    repeat (3) @(posedge clk);
  endtask

  int d0, e0, n0, errk, k;
  logic rdy_after, busy_after;

  initial begin
    // Reset with en already high: in_ready must stay low.
    rst = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_oe", swim_oe, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);

    // Command 3'b001 with ACK.
    d0 = done_cycles; e0 = err_cycles; n0 = bits_seen;
    send(8'h01, 1'b1);
    wait_bits(n0 + 5);
    respond(12);
    wait_resp();
    chk("cmd_done", done_cycles - d0, 1);
    chk("cmd_err", err_cycles - e0, 0);

    // Data 0xA5 with ACK.
    d0 = done_cycles; e0 = err_cycles; n0 = bits_seen;
    send(8'hA5, 1'b0);
    wait_bits(n0 + 10);
    respond(12);
    wait_resp();
    chk("a5_done", done_cycles - d0, 1);
    chk("a5_err", err_cycles - e0, 0);

    // Data 0x3C: NACK, NACK, ACK.
    d0 = done_cycles; e0 = err_cycles; n0 = bits_seen;
    send(8'h3C, 1'b0);
    wait_bits(n0 + 10);
    push_frame(8'h3C, 1'b0);
    respond(120);
    wait_bits(n0 + 20);
    push_frame(8'h3C, 1'b0);
    respond(120);
    wait_bits(n0 + 30);
    respond(12);
    wait_resp();
    chk("retry_done", done_cycles - d0, 1);
    chk("retry_err", err_cycles - e0, 0);

    // Silent target: err exactly 1056 clocks into ACK_WAIT.
    d0 = done_cycles; e0 = err_cycles;
    send(8'h55, 1'b0);
    errk = 0; rdy_after = 1'b0; busy_after = 1'b1;
    for (k = 1; k < 3000; k++) begin
      @(posedge clk);
      #1;
      if (errk != 0) begin
        rdy_after = in_ready;
        busy_after = busy;
        break;
      end
      if (err) errk = k;
    end
    chk("timeout_latency", errk, 10 * BitLen + 1056 - 1);
    chk("ready_after_err", rdy_after, 1);
    chk("idle_after_err", busy_after, 0);
    repeat (3) @(posedge clk);
    chk("timeout_err", err_cycles - e0, 1);
    chk("timeout_done", done_cycles - d0, 0);

    // Reset in the middle of a data bit: pin released at once, frame discarded.
    d0 = done_cycles; e0 = err_cycles;
    send(8'h00, 1'b0);
    repeat (5 * BitLen + 10) @(posedge clk);
    #1;
    chk("oe_before_rst", swim_oe, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_oe", swim_oe, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    exp_q.delete();
    repeat (4) begin
      @(negedge clk);
      chk("midrst_ready_hold", in_ready, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_midrst", in_ready, 1);
    chk("midrst_done", done_cycles - d0, 0);
    chk("midrst_err", err_cycles - e0, 0);

    // in_valid held while en is low: no accept until en rises.
    d0 = done_cycles; e0 = err_cycles; n0 = bits_seen;
    @(negedge clk);
    en = 1'b0;
    in_data = 8'h81;
    in_is_cmd = 1'b0;
    in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("en_low_ready", in_ready, 0);
      chk("en_low_oe", swim_oe, 0);
    end
    en = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    push_frame(8'h81, 1'b0);
    chk("en_rise_accept", swim_oe, 1);
    // Dropping en mid-frame must not abort the frame.
    repeat (300) @(posedge clk);
    en = 1'b0;
    wait_bits(n0 + 10);
    respond(12);
    wait_resp();
    chk("en_drop_done", done_cycles - d0, 1);
    chk("en_drop_err", err_cycles - e0, 0);
    chk("en_low_no_ready", in_ready, 0);
    en = 1'b1;
    @(negedge clk);
    chk("en_high_ready", in_ready, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
